gb_wave_ram: RTL and testbench

- 16-byte waveform RAM (32 × 4-bit samples) for the custom wave channel (channel 3), mapped at CPU FF30–FF3F.
- Sits directly upstream of gb_customWaveChannel: it answers that channel's wave_addr with wave_data, and it arbitrates CPU read/write access.
- Models DMG behaviour while the channel is active: CPU accesses are redirected to the byte the channel last fetched, and succeed only in a short window after that fetch.

---
 rtl/gb_apu_pkg.sv | 12 +
 rtl/gb_wave_ram.sv | 96 +++++++++
 tb/tb_gb_wave_ram.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/gb_apu_pkg.sv
// Shared APU definitions.
// Holds the wave RAM geometry, its CPU base address and the byte/index
// types used by the wave RAM and the custom wave channel.
package gb_apu_pkg;

    localparam int          WAVE_RAM_BYTES = 16;
    localparam logic [15:0] WAVE_RAM_BASE  = 16'hFF30;

    typedef logic [7:0] wave_byte_t;
    typedef logic [3:0] wave_idx_t;

endpackage

// File: rtl/gb_wave_ram.sv
// gb_wave_ram: 16-byte channel-3 waveform RAM (CPU FF30-FF3F).
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   cpu_addr           CPU byte index (FF30 + n)
//   cpu_wdata, cpu_we  CPU write data and one-cycle write strobe
//   cpu_re             one-cycle read strobe
//   cpu_rdata          read data, valid with cpu_rvalid (held otherwise)
//   cpu_rvalid         one-cycle pulse, the cycle after cpu_re
//   wave_addr          byte index requested by the wave channel
//   wave_data          mem[wave_addr], combinational
//   channel_active     channel 3 enable
//
// With DMG_QUIRK set and the channel running, CPU accesses land on the byte
// the channel last fetched, and only succeed for WINDOW_CYCLES cycles after
// that fetch; failed reads return 8'hFF and failed writes are dropped.
module gb_wave_ram
    import gb_apu_pkg::*;
#(
    parameter bit         DMG_QUIRK     = 1'b1,
    parameter int         WINDOW_CYCLES = 2,
    parameter wave_byte_t INIT_EVEN     = 8'h00,
    parameter wave_byte_t INIT_ODD      = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_we,
    input  logic       cpu_re,
    output logic [7:0] cpu_rdata,
    output logic       cpu_rvalid,
    input  logic [3:0] wave_addr,
    output logic [7:0] wave_data,
    input  logic       channel_active
);

    localparam logic [3:0] WIN_LOAD = 4'(WINDOW_CYCLES);

    wave_byte_t mem [WAVE_RAM_BYTES];
    wave_idx_t  fetch_addr;
    wave_idx_t  prev_wave_addr;
    logic       prev_active;
    logic [3:0] win_cnt;

    logic       fetch;
    logic       redirect;
    logic       allowed;
    wave_idx_t  eff_addr;

    assign wave_data = mem[wave_addr];

    // A fetch is a new byte request, or the first active cycle after idle.
    assign fetch    = channel_active & ((wave_addr != prev_wave_addr) | ~prev_active);

    // Strobes see the registered fetch_addr/win_cnt, so a fetch in the same
    // cycle only affects strobes from the next cycle on.
    assign redirect = DMG_QUIRK & channel_active;
    assign eff_addr = redirect ? fetch_addr : cpu_addr;
    assign allowed  = ~redirect | (win_cnt != 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WAVE_RAM_BYTES; i++) begin
                mem[i] <= (i % 2 == 1) ? INIT_ODD : INIT_EVEN;
            end
            cpu_rdata      <= 8'h00;
            cpu_rvalid     <= 1'b0;
            fetch_addr     <= '0;
            win_cnt        <= 4'd0;
            prev_wave_addr <= '0;
            prev_active    <= 1'b0;
        end else begin
            prev_wave_addr <= wave_addr;
            prev_active    <= channel_active;

            if (fetch) begin
                fetch_addr <= wave_addr;
                win_cnt    <= WIN_LOAD;
            end else if (win_cnt != 4'd0) begin
                win_cnt <= win_cnt - 4'd1;
            end

            // Read samples the pre-write byte because both use the old array.
            cpu_rvalid <= cpu_re;
            if (cpu_re) begin
                cpu_rdata <= allowed ? mem[eff_addr] : 8'hFF;
            end

            if (cpu_we && allowed) begin
                mem[eff_addr] <= cpu_wdata;
            end
        end
    end

endmodule

// File: tb/tb_gb_wave_ram.sv
module tb_gb_wave_ram;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_we;
    logic       cpu_re;
    logic [7:0] cpu_rdata;
    logic       cpu_rvalid;
    logic [3:0] wave_addr;
    logic [7:0] wave_data;
    logic       channel_active;

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;
    int n_pushes = 0;

    logic [7:0] exp_q [$];
    logic [7:0] ref_mem [16];

    gb_wave_ram #(
        .DMG_QUIRK     (1'b1),
        .WINDOW_CYCLES (2),
        .INIT_EVEN     (8'h00),
        .INIT_ODD      (8'hFF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_we         (cpu_we),
        .cpu_re         (cpu_re),
        .cpu_rdata      (cpu_rdata),
        .cpu_rvalid     (cpu_rvalid),
        .wave_addr      (wave_addr),
        .wave_data      (wave_data),
        .channel_active (channel_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Read-data monitor: every rvalid pulse must match the oldest queued read.
    always @(negedge clk) begin
        if (cpu_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rvalid_unexpected", 32'(cpu_rvalid), 32'd0);
            end else begin
                n_pops++;
                check("rdata", 32'(cpu_rdata), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = (i % 2 == 1) ? 8'hFF : 8'h00;
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        tick();
        cpu_we    = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] a, input logic [7:0] exp);
        cpu_addr = a;
        cpu_re   = 1'b1;
        exp_q.push_back(exp);
        n_pushes++;
        tick();
        cpu_re   = 1'b0;
    endtask

    // Only meaningful while channel_active=0 (wave_addr changes cause fetches).
    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            wave_addr = 4'(i);
            #1;
            check(tag, 32'(wave_data), 32'(ref_mem[i]));
        end
    endtask

    initial begin
        reset          = 1'b1;
        cpu_addr       = 4'd0;
        cpu_wdata      = 8'h55;
        cpu_we         = 1'b1;   // strobes during reset must be ignored
        cpu_re         = 1'b1;
        wave_addr      = 4'd0;
        channel_active = 1'b0;
        ref_reset();

        // Reset
        tick();
        reset  = 1'b0;
        cpu_we = 1'b0;
        cpu_re = 1'b0;
        check("rst_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_rdata", 32'(cpu_rdata), 32'h00);
        sweep("rst_mem");
        tick();

        // Inactive write/read
        wave_addr = 4'd7;
        #1;
        check("wave7_before", 32'(wave_data), 32'hFF);
        cpu_write(4'd7, 8'hA5);
        ref_mem[7] = 8'hA5;
        check("wave7_after", 32'(wave_data), 32'hA5);
        cpu_read(4'd7, 8'hA5);
        tick();
        check("rvalid_low", 32'(cpu_rvalid), 32'd0);

        // Active, in window
        cpu_write(4'd3, 8'h3C);
        ref_mem[3] = 8'h3C;
        wave_addr      = 4'd3;
        channel_active = 1'b1;
        tick();                        // fetch: fetch_addr=3, win=2
        cpu_read(4'd9, 8'h3C);         // win=2 -> redirected to 3
        cpu_write(4'd9, 8'h77);        // win=1 -> still allowed, lands on 3
        ref_mem[3] = 8'h77;
        check("wave3_in_window", 32'(wave_data), 32'h77);

        // Active, out of window (win reached 0)
        tick();
        cpu_read(4'd3, 8'hFF);
        cpu_write(4'd5, 8'h11);        // dropped

        // Fetch in same cycle as strobe: old window (closed) applies
        wave_addr = 4'd10;
        cpu_read(4'd3, 8'hFF);
        cpu_read(4'd3, ref_mem[10]);   // new window, redirected to 10

        // Deactivate: access reverts to cpu_addr immediately
        channel_active = 1'b0;
        cpu_read(4'd7, 8'hA5);
        tick();
        sweep("mem_after_active");

        // Simultaneous strobes
        cpu_write(4'd5, 8'h10);
        ref_mem[5] = 8'h10;
        cpu_addr  = 4'd5;
        cpu_wdata = 8'h20;
        cpu_we    = 1'b1;
        cpu_re    = 1'b1;
        exp_q.push_back(8'h10);
        n_pushes++;
        tick();
        cpu_we = 1'b0;
        cpu_re = 1'b0;
        ref_mem[5] = 8'h20;
        cpu_read(4'd5, 8'h20);
        wave_addr = 4'd5;
        #1;
        check("wave5_simul", 32'(wave_data), 32'h20);

        // Reset mid-window
        wave_addr      = 4'd2;
        channel_active = 1'b1;
        tick();                        // fetch opens a window at 2
        reset     = 1'b1;
        wave_addr = 4'd5;
        tick();
        reset = 1'b0;
        ref_reset();
        check("wave5_reinit", 32'(wave_data), 32'hFF);
        cpu_read(4'd0, 8'hFF);         // win_cnt cleared; same-cycle fetch not yet visible
        cpu_read(4'd0, ref_mem[5]);    // window from post-reset fetch, redirected to 5
        cpu_write(4'd0, 8'hC3);        // win=1 -> lands on 5
        ref_mem[5] = 8'hC3;
        check("wave5_post_reset_wr", 32'(wave_data), 32'hC3);
        channel_active = 1'b0;
        tick();
        sweep("mem_final");

        tick();
        tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("sb_count", 32'(n_pops), 32'(n_pushes));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
